// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: default sizes, FSM encoding, index helpers.
package shared_mem_arbiter_pkg;

  localparam int unsigned SMEM_NUM_CORES = 16;
  localparam int unsigned SMEM_ADDR_W    = 8;
  localparam int unsigned SMEM_DATA_W    = 8;
  localparam int unsigned SMEM_MEM_LAT   = 1;
`ifdef SMEM_ARB_LOCK_EN
  localparam int unsigned SMEM_LOCK_MAX  = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_priority_pick
  import shared_mem_arbiter_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned j;
    // NOTE: every output is defaulted before the scan, so no path can infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter for the single-port shared data memory; one access in flight at a time.
// Define SMEM_ARB_LOCK_EN to add the Lock port, letting a core keep the grant up to LOCK_MAX times.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_OF_CORES = SMEM_NUM_CORES,
  parameter int unsigned ADDR_W       = SMEM_ADDR_W,
  parameter int unsigned DATA_W       = SMEM_DATA_W,
  parameter int unsigned MEM_LAT      = SMEM_MEM_LAT
`ifdef SMEM_ARB_LOCK_EN
  ,
  parameter int unsigned LOCK_MAX     = SMEM_LOCK_MAX
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_OF_CORES-1:0]        Req,
  input  logic [NUM_OF_CORES-1:0]        We,
  input  logic [NUM_OF_CORES*ADDR_W-1:0] Addr,
  input  logic [NUM_OF_CORES*DATA_W-1:0] Wdata,
`ifdef SMEM_ARB_LOCK_EN
  input  logic [NUM_OF_CORES-1:0]        Lock,
`endif
  output logic [NUM_OF_CORES-1:0]        Ack,
  output logic [DATA_W-1:0]              Rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int unsigned IDX_W  = idx_width(NUM_OF_CORES);
  localparam int unsigned CNT_W  = idx_width(MEM_LAT);
`ifdef SMEM_ARB_LOCK_EN
  localparam int unsigned LOCK_W = idx_width(LOCK_MAX);
`endif

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d, win_q, win_d;
  logic [IDX_W-1:0]        ptr_adv, pick_ptr, pick_idx, sel;
  logic [NUM_OF_CORES-1:0] win_oh_q, win_oh_d, ack_q, ack_d;
  logic [NUM_OF_CORES-1:0] pick_req, pick_grant;
  logic                    pick_any, regrant;
  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`ifdef SMEM_ARB_LOCK_EN
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
`endif

  assign ptr_adv = IDX_W'(rr_next(32'(win_q), NUM_OF_CORES));
  assign sel     = regrant ? win_q : pick_idx;

  // In DONE the finishing core sits out its own Ack cycle and the scan starts just past it.
  always_comb begin
    pick_req = Req;
    pick_ptr = ptr_q;
    regrant  = 1'b0;
    if (state_q == ST_DONE) begin
      pick_req = Req & ~ack_q;
      pick_ptr = ptr_adv;
`ifdef SMEM_ARB_LOCK_EN
      regrant  = Lock[win_q] && Req[win_q] && (lock_cnt_q < LOCK_W'(LOCK_MAX - 1));
`endif
    end
  end

  rr_priority_pick #(
    .N     (NUM_OF_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    win_oh_d    = win_oh_q;
    ack_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
`ifdef SMEM_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && !regrant) ptr_d = ptr_adv;
        if (regrant || pick_any) begin
          if (!regrant) begin
            win_d    = pick_idx;
            win_oh_d = pick_grant;
          end
          mem_en_d    = 1'b1;
          mem_we_d    = We[sel];
          mem_addr_d  = Addr[sel*ADDR_W +: ADDR_W];
          mem_wdata_d = Wdata[sel*DATA_W +: DATA_W];
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef SMEM_ARB_LOCK_EN
        lock_cnt_d = regrant ? lock_cnt_q + 1'b1 : '0;
`endif
      end
      ST_ISSUE: begin
        cnt_d    = CNT_W'(MEM_LAT - 1);
        mem_we_d = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          ack_d   = win_oh_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      win_oh_q    <= '0;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
`ifdef SMEM_ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      win_oh_q    <= win_oh_d;
      ack_q       <= ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
`ifdef SMEM_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign Ack       = ack_q;
  assign Rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
